// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin arbitration of two requesters onto one two-stage adder pipeline
module adder_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid0,
  input  logic [WIDTH-1:0] in_a0,
  input  logic [WIDTH-1:0] in_b0,
  input  logic             in_valid1,
  input  logic [WIDTH-1:0] in_a1,
  input  logic [WIDTH-1:0] in_b1,
  output logic             in_ready0,
  output logic             in_ready1,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_sum,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt0,
  output logic [CNT_W-1:0] issue_cnt1
);
  logic             rr_ptr_q, rr_ptr_d;
  logic             s1_valid_q, s1_valid_d, s1_id_q, s1_id_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d, s2_id_q, s2_id_d;
  logic [WIDTH:0]   s2_sum_q, s2_sum_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             acc;

  // grants ignore pipeline occupancy; rr_ptr only breaks ties
  always_comb begin
    in_ready0  = !reset && enable && in_valid0 && (!in_valid1 || !rr_ptr_q);
    in_ready1  = !reset && enable && in_valid1 && (!in_valid0 || rr_ptr_q);
    acc        = in_ready0 | in_ready1;
    rr_ptr_d   = acc ? in_ready0 : rr_ptr_q;
    s1_valid_d = acc;
    s1_id_d    = in_ready1;
    s1_a_d     = in_ready1 ? in_a1 : in_a0;
    s1_b_d     = in_ready1 ? in_b1 : in_b0;
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
    s2_sum_d   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    cnt0_d     = cnt0_q + CNT_W'(in_ready0);
    cnt1_d     = cnt1_q + CNT_W'(in_ready1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= 1'b0;
      s2_sum_q   <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_sum_q   <= s2_sum_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign rsp_valid  = s2_valid_q;
  assign rsp_id     = s2_id_q;
  assign rsp_sum    = s2_sum_q;
  assign busy       = s1_valid_q | s2_valid_q;
  assign issue_cnt0 = cnt0_q;
  assign issue_cnt1 = cnt1_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed checks of arbitration, pipeline latency, carry, enable, reset and counter wrap
module tb_adder_share_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [31:0] in_a0 = '0, in_b0 = '0, in_a1 = '0, in_b1 = '0;
  logic        in_ready0, in_ready1, rsp_valid, rsp_id, busy;
  logic [32:0] rsp_sum;
  logic [3:0]  issue_cnt0, issue_cnt1;
  int          total = 0, passed = 0;

  adder_share_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid0(in_valid0), .in_a0(in_a0), .in_b0(in_b0),
    .in_valid1(in_valid1), .in_a1(in_a1), .in_b1(in_b1),
    .in_ready0(in_ready0), .in_ready1(in_ready1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy(busy), .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic issue_one(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
    if (id) begin in_valid1 = 1'b1; in_a1 = a; in_b1 = b; end
    else begin in_valid0 = 1'b1; in_a0 = a; in_b0 = b; end
    #1;
    check("single_ready", {in_ready1, in_ready0}, id ? 64'd2 : 64'd1);
    tick;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    check("single_busy", busy, 1);
    check("single_not_yet", rsp_valid, 0);
    tick;
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_id", rsp_id, id);
    check("single_rsp_sum", rsp_sum, exp);
    tick;
    check("single_rsp_drop", rsp_valid, 0);
    check("single_idle", busy, 0);
  endtask

  initial begin
    #3;
    enable = 1'b1;
    in_valid0 = 1'b1;
    #1;
    check("rst_ready0", in_ready0, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt0", issue_cnt0, 0);
    in_valid0 = 1'b0;
    tick;
    reset = 1'b0;
    // single operation from requester 0
    issue_one(1'b0, 32'd3827, 32'd9273, 33'd13100);
    check("single_cnt0", issue_cnt0, 1);
    // fresh reset so contention starts from rr_ptr=0
    reset = 1'b1;
    #1;
    reset = 1'b0;
    in_valid0 = 1'b1; in_a0 = 32'd0;   in_b0 = 32'd9253;
    in_valid1 = 1'b1; in_a1 = 32'd200; in_b1 = 32'd100;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("cont_ready0", in_ready0, (i % 2) == 0);
      check("cont_ready1", in_ready1, (i % 2) == 1);
      tick;
      if (i == 5) begin in_valid0 = 1'b0; in_valid1 = 1'b0; end
      if (i >= 1) begin
        check("cont_rsp_valid", rsp_valid, 1);
        check("cont_rsp_id", rsp_id, ((i - 1) % 2) == 1);
        check("cont_rsp_sum", rsp_sum, ((i - 1) % 2) == 1 ? 64'd300 : 64'd9253);
      end
    end
    tick;
    check("cont_last_valid", rsp_valid, 1);
    check("cont_last_sum", rsp_sum, 300);
    tick;
    check("cont_drain", rsp_valid, 0);
    check("cont_cnt0", issue_cnt0, 3);
    check("cont_cnt1", issue_cnt1, 3);
    // carries out of the top bit
    issue_one(1'b1, 32'h0FFFFFFF, 32'hFFFFFFEF, 33'h1_0FFFFFEE);
    issue_one(1'b0, 32'hFFFFFFFF, 32'h00000001, 33'h1_00000000);
    check("carry_cnt0", issue_cnt0, 4);
    check("carry_cnt1", issue_cnt1, 4);
    // enable drop after two accepts; rr_ptr=1 here so req1 goes first
    in_valid0 = 1'b1; in_a0 = 32'd1;  in_b0 = 32'd2;
    in_valid1 = 1'b1; in_a1 = 32'd10; in_b1 = 32'd20;
    tick;
    tick;
    enable = 1'b0;
    #1;
    check("en_ready0", in_ready0, 0);
    check("en_ready1", in_ready1, 0);
    check("en_rsp1_valid", rsp_valid, 1);
    check("en_rsp1_sum", rsp_sum, 30);
    check("en_rsp1_id", rsp_id, 1);
    tick;
    check("en_rsp2_sum", rsp_sum, 3);
    check("en_rsp2_id", rsp_id, 0);
    check("en_busy_last", busy, 1);
    tick;
    check("en_rsp_end", rsp_valid, 0);
    check("en_busy_end", busy, 0);
    tick;
    check("en_cnt0", issue_cnt0, 5);
    check("en_cnt1", issue_cnt1, 5);
    // reset between edges with two ops in flight
    enable = 1'b1;
    tick;
    tick;
    reset = 1'b1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_rsp_sum", rsp_sum, 0);
    check("mid_busy", busy, 0);
    check("mid_cnt0", issue_cnt0, 0);
    check("mid_cnt1", issue_cnt1, 0);
    tick;
    reset = 1'b0;
    tick;
    check("post_rst_rsp1", rsp_valid, 0);
    tick;
    check("post_rst_rsp2", rsp_valid, 0);
    in_valid0 = 1'b1;
    in_valid1 = 1'b1;
    #1;
    check("post_rst_grant", {in_ready1, in_ready0}, 1);
    // 17 accepts on a 4-bit counter wraps to 1
    in_valid1 = 1'b0;
    for (int i = 0; i < 17; i++) tick;
    in_valid0 = 1'b0;
    #1;
    check("wrap_cnt0", issue_cnt0, 1);
    check("wrap_cnt1", issue_cnt1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand width; sum width is WIDTH+1.
REQ-002 Parameter: CNT_W, 16, width of per-requester issue counters.
REQ-003 Port: clock  input  1  single clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: enable  input  1  when low, no new grants; in-flight operations still drain.
REQ-006 Port: in_valid0 / in_valid1  input  1 each  requester 0/1 has an operand pair.
REQ-007 Port: in_a0, in_b0 / in_a1, in_b1  input  WIDTH each  operands of requester 0/1.
REQ-008 Port: in_ready0 / in_ready1  output  1 each  grant; handshake completes when valid and ready are both high at a rising edge.
REQ-009 Port: rsp_valid  output  1  rsp_sum and rsp_id hold a completed result this cycle.
REQ-010 Port: rsp_id  output  1  requester that issued the result.
REQ-011 Port: rsp_sum  output  WIDTH+1  unsigned sum, carry in MSB.
REQ-012 Port: busy  output  1  any operation in flight (stage 1 or stage 2 valid).
REQ-013 Port: issue_cnt0 / issue_cnt1  output  CNT_W each  accepted operations per requester.

Function
REQ-014 Block SHALL contain a two-stage add pipeline: stage 1 registers operands, id and valid; stage 2 registers the (WIDTH+1)-bit sum, id and valid.
REQ-015 Stage-2 registers SHALL drive rsp_valid, rsp_id, rsp_sum directly (no combinational path from inputs).
REQ-016 Handshake accepted at rising edge k SHALL produce rsp_valid=1 with its result in the cycle after edge k+1, for exactly one cycle.
REQ-017 Pipeline SHALL accept one operation per cycle with no bubbles; responses have no backpressure.
REQ-018 in_ready0/in_ready1 SHALL be combinational from in_valid*, enable, rr_ptr; at most one high per cycle; both low when enable=0.
REQ-019 One requester valid and enable=1: that requester SHALL be granted.
REQ-020 Both valid and enable=1: requester indexed by rr_ptr SHALL be granted.
REQ-021 After any accepted handshake, rr_ptr SHALL point to the non-granted requester; unchanged when no handshake.
REQ-022 in_ready SHALL NOT depend on pipeline occupancy; a valid requester is never starved beyond one cycle of contention.
REQ-023 Non-accepted cycles SHALL insert a bubble (stage-1 valid=0); rsp_valid stays 0 for bubbles.
REQ-024 Sum SHALL be zero-extended in_a + in_b; 32'hFFFFFFFF+32'h1 yields 33'h1_00000000.
REQ-025 issue_cntN SHALL increment on each accepted handshake of requester N, wrapping from all-ones to 0.
REQ-026 busy SHALL equal stage-1 valid OR stage-2 valid.
REQ-027 enable falling mid-stream SHALL not cancel in-flight operations; they complete at normal latency.

Reset
REQ-028 Reset assertion SHALL immediately clear stage valids, rsp_valid, rsp_id, rsp_sum, busy, both counters, and set rr_ptr=0, independent of clock.
REQ-029 In-flight operations at reset SHALL be discarded with no rsp_valid after reset release.
REQ-030 in_ready0/in_ready1 SHALL be 0 while reset is high.
REQ-031 First contended grant after reset SHALL go to requester 0.

Verification
REQ-032 Single op: requester 0 presents 3827+9273 for one cycle -> rsp_valid one cycle, 2 edges later, rsp_id=0, rsp_sum=13100, issue_cnt0=1.
REQ-033 Contention: both valid continuously, req0 0+9253, req1 200+100 -> grants alternate 0,1,0,1; responses alternate 9253 and 300, one per cycle, no gaps.
REQ-034 Carry: requester 1 sends 32'h0FFFFFFF+32'hFFFFFFEF -> rsp_sum=33'h1_0FFFFFEE, rsp_id=1.
REQ-035 Enable: both valid, enable dropped after 2 accepts -> in_ready both 0, two pending results still emitted, busy falls after last, counters frozen.
REQ-036 Reset mid-flight: accept two ops, assert reset between clock edges -> outputs clear immediately, no rsp_valid after release, next contended grant to requester 0.
REQ-037 Counter wrap: CNT_W=4, 17 accepts on requester 0 -> issue_cnt0=1.
